// File: rtl/pq_pkg.sv
// Shared types and defaults for the priority-queue request shaper.
//   pq_op_t  : request opcode (NOP / ENQ / DEQ / REPL)
//   kv_t     : packed {key, val} word carried with ENQ and REPL
//   PQ_*_SPACING : default minimum cycles between heap operations
package pq_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
    localparam int KV_WIDTH  = KEY_WIDTH + VAL_WIDTH;

    typedef enum logic [1:0] {
        PQ_NOP  = 2'b00,
        PQ_ENQ  = 2'b01,
        PQ_DEQ  = 2'b10,
        PQ_REPL = 2'b11
    } pq_op_t;

    typedef logic [KV_WIDTH-1:0] kv_t;

    localparam int PQ_ENQ_SPACING  = 8;
    localparam int PQ_DEQ_SPACING  = 4;
    localparam int PQ_REPL_SPACING = 4;

endpackage

// File: rtl/pq_req_fifo.sv
// Request buffer for the PQ shaper: synchronous FIFO of {op, kv}.
// Build option: PQ_SHAPER_COALESCE_EN adds the next-to-head peek ports.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_op/kv  write one entry (caller guarantees !full)
//   pop1 / pop2       remove one / two entries (caller guarantees count)
//   head_op/kv        entry at the read pointer
//   next_op/kv        entry behind the head (coalesce build only)
//   count, full       occupancy, registered
import pq_pkg::*;

module pq_req_fifo #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  pq_op_t           push_op,
    input  kv_t              push_kv,
    input  logic             pop1,
    input  logic             pop2,
    output pq_op_t           head_op,
    output kv_t              head_kv,
`ifdef PQ_SHAPER_COALESCE_EN
    output pq_op_t           next_op,
    output kv_t              next_kv,
`endif
    output logic [CNT_W-1:0] count,
    output logic             full
);

    pq_op_t           op_mem [DEPTH];
    kv_t              kv_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] push_amt;
    logic [CNT_W-1:0] pop_amt;

    assign push_amt = CNT_W'(push);
    assign pop_amt  = pop2 ? CNT_W'(2) : CNT_W'(pop1);
    assign full     = (count == CNT_W'(DEPTH));

    assign head_op = op_mem[rd_ptr];
    assign head_kv = kv_mem[rd_ptr];
`ifdef PQ_SHAPER_COALESCE_EN
    assign next_op = op_mem[rd_ptr + PTR_W'(1)];
    assign next_kv = kv_mem[rd_ptr + PTR_W'(1)];
`endif

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= push_op;
            kv_mem[wr_ptr] <= push_kv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop2) begin
                rd_ptr <= rd_ptr + PTR_W'(2);
            end else if (pop1) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + push_amt - pop_amt;
        end
    end

endmodule

// File: rtl/pq_req_shaper.sv
// Front-end shaper for the pipelined-heap PQ. Buffers producer requests
// and issues them as single-cycle enq/deq strobes, holding off each next
// strobe for the spacing the heap pipeline needs after the previous op.
// Build option: PQ_SHAPER_COALESCE_EN merges a queued DEQ followed by an
// ENQ into one replace strobe.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       producer handshake
//   req_op, req_kv            request opcode and {key,val}
//   enq, deq, kvi             registered strobes and data to the PQ
//   pq_empty, pq_full         PQ status, sampled only in IDLE
//   err_underflow             one-cycle pulse when a DEQ hits an empty PQ
//   busy                      FIFO non-empty or spacing gap running
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | free to issue; evaluates FIFO head against PQ flags
// GAP   | spacing down-counter running after a strobe; no issue
import pq_pkg::*;

module pq_req_shaper #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ENQ_SPACING  = PQ_ENQ_SPACING,
    parameter int DEQ_SPACING  = PQ_DEQ_SPACING,
    parameter int REPL_SPACING = PQ_REPL_SPACING
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   req_valid,
    output logic   req_ready,
    input  pq_op_t req_op,
    input  kv_t    req_kv,
    output logic   enq,
    output logic   deq,
    output kv_t    kvi,
    input  logic   pq_empty,
    input  logic   pq_full,
    output logic   err_underflow,
    output logic   busy
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SP_MAX = (ENQ_SPACING > DEQ_SPACING)
                          ? ((ENQ_SPACING > REPL_SPACING) ? ENQ_SPACING : REPL_SPACING)
                          : ((DEQ_SPACING > REPL_SPACING) ? DEQ_SPACING : REPL_SPACING);
    localparam int SP_W   = $clog2(SP_MAX + 1);

    localparam logic [SP_W-1:0] SP_ENQ  = SP_W'(ENQ_SPACING - 1);
    localparam logic [SP_W-1:0] SP_DEQ  = SP_W'(DEQ_SPACING - 1);
    localparam logic [SP_W-1:0] SP_REPL = SP_W'(REPL_SPACING - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        nxt_state;
    logic [SP_W-1:0]   gap_cnt;
    logic [SP_W-1:0]   nxt_cnt;
    logic [SP_W-1:0]   load_val;
    logic              load_go;

    logic              nxt_enq;
    logic              nxt_deq;
    kv_t               nxt_kvi;
    logic              nxt_err;

    logic              push;
    logic              pop1;
    logic              pop2;
    pq_op_t            head_op;
    kv_t               head_kv;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full;

`ifdef PQ_SHAPER_COALESCE_EN
    pq_op_t            next_op;
    kv_t               next_kv;
    logic              coalesce_hit;
`endif

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready && (req_op != PQ_NOP);
    assign busy      = (fifo_count != '0) || (state == ST_GAP);

    pq_req_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_op (req_op),
        .push_kv (req_kv),
        .pop1    (pop1),
        .pop2    (pop2),
        .head_op (head_op),
        .head_kv (head_kv),
`ifdef PQ_SHAPER_COALESCE_EN
        .next_op (next_op),
        .next_kv (next_kv),
`endif
        .count   (fifo_count),
        .full    (fifo_full)
    );

`ifdef PQ_SHAPER_COALESCE_EN
    // A DEQ followed by an ENQ on a non-empty heap is one replace operation.
    assign coalesce_hit = (fifo_count >= FCNT_W'(2)) && (head_op == PQ_DEQ)
                       && (next_op == PQ_ENQ) && !pq_empty;
`endif

    always_comb begin
        nxt_state = state;
        nxt_cnt   = gap_cnt;
        nxt_enq   = 1'b0;
        nxt_deq   = 1'b0;
        nxt_kvi   = kvi;
        nxt_err   = 1'b0;
        pop1      = 1'b0;
        pop2      = 1'b0;
        load_go   = 1'b0;
        load_val  = '0;
        case (state)
            ST_IDLE: begin
                if (fifo_count != '0) begin
`ifdef PQ_SHAPER_COALESCE_EN
                    if (coalesce_hit) begin
                        pop2     = 1'b1;
                        nxt_enq  = 1'b1;
                        nxt_deq  = 1'b1;
                        nxt_kvi  = next_kv;
                        load_go  = 1'b1;
                        load_val = SP_REPL;
                    end else
`endif
                    begin
                        case (head_op)
                            PQ_ENQ: begin
                                // Full heap: hold the head until space frees up.
                                if (!pq_full) begin
                                    pop1     = 1'b1;
                                    nxt_enq  = 1'b1;
                                    nxt_kvi  = head_kv;
                                    load_go  = 1'b1;
                                    load_val = SP_ENQ;
                                end
                            end
                            PQ_DEQ: begin
                                pop1 = 1'b1;
                                if (!pq_empty) begin
                                    nxt_deq  = 1'b1;
                                    load_go  = 1'b1;
                                    load_val = SP_DEQ;
                                end else begin
                                    nxt_err  = 1'b1;
                                end
                            end
                            PQ_REPL: begin
                                // Replace on an empty heap degenerates to a plain insert.
                                pop1    = 1'b1;
                                nxt_enq = 1'b1;
                                nxt_kvi = head_kv;
                                load_go = 1'b1;
                                if (!pq_empty) begin
                                    nxt_deq  = 1'b1;
                                    load_val = SP_REPL;
                                end else begin
                                    load_val = SP_ENQ;
                                end
                            end
                            default: begin
                                pop1 = 1'b1;
                            end
                        endcase
                    end
                end
            end
            default: begin
                // Leaving GAP as the count reaches zero lets the IDLE decision
                // land one cycle before the earliest legal strobe.
                if (gap_cnt <= SP_W'(1)) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt   = gap_cnt - SP_W'(1);
                end
            end
        endcase
        if (load_go) begin
            nxt_cnt   = load_val;
            nxt_state = (load_val != '0) ? ST_GAP : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            gap_cnt       <= '0;
            enq           <= 1'b0;
            deq           <= 1'b0;
            kvi           <= '0;
            err_underflow <= 1'b0;
        end else begin
            state         <= nxt_state;
            gap_cnt       <= nxt_cnt;
            enq           <= nxt_enq;
            deq           <= nxt_deq;
            kvi           <= nxt_kvi;
            err_underflow <= nxt_err;
        end
    end

endmodule

// File: tb/tb_pq_req_shaper.sv
// Directed bench for pq_req_shaper: handshake, latency, spacing, empty/full
// handling, optional DEQ+ENQ coalescing and asynchronous reset.
module tb_pq_req_shaper;
    import pq_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   req_valid = 1'b0;
    logic   req_ready;
    pq_op_t req_op = PQ_NOP;
    kv_t    req_kv = '0;
    logic   enq;
    logic   deq;
    kv_t    kvi;
    logic   pq_empty = 1'b1;
    logic   pq_full = 1'b0;
    logic   err_underflow;
    logic   busy;

    typedef struct {
        int   cyc;
        logic e;
        logic d;
        kv_t  kv;
    } strobe_t;

    strobe_t strobes[$];
    int      cyc = 0;
    int      n_checks = 0;
    int      n_err = 0;

    pq_req_shaper dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_kv        (req_kv),
        .enq           (enq),
        .deq           (deq),
        .kvi           (kvi),
        .pq_empty      (pq_empty),
        .pq_full       (pq_full),
        .err_underflow (err_underflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && (enq || deq)) strobes.push_back('{cyc, enq, deq, kvi});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input pq_op_t op, input kv_t kv, output int acc, output int waits);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_kv    = kv;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!req_ready) chk("send_ready_timeout", req_ready, 1);
        tick();
        acc       = cyc;
        waits     = n;
        req_valid = 1'b0;
        req_op    = PQ_NOP;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_strobes(input int want);
        int k = 0;
        while (strobes.size() < want && k < 150) begin
            tick();
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, w0, w1, w2, r, exp_n;

        // Reset state
        repeat (3) tick();
        chk("rst_enq", enq, 0);
        chk("rst_deq", deq, 0);
        chk("rst_kvi", kvi, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        rst = 1'b0;
        tick();

        // Single ENQ: strobe in the cycle after acceptance edge + 1
        pq_empty = 1'b1;
        send(PQ_ENQ, 16'h0F0F, a0, w0);
        tick();
        chk("enq1_strobe", {enq, deq}, 2'b10);
        chk("enq1_kvi", kvi, 16'h0F0F);
        tick();
        chk("enq1_one_cycle", enq, 0);
        repeat (5) tick();
        chk("enq1_busy_in_gap", busy, 1);
        tick();
        chk("enq1_busy_done", busy, 0);
        chk("enq1_kvi_hold", kvi, 16'h0F0F);

        // Back-to-back ENQ, ENQ, DEQ
        pq_empty = 1'b0;
        strobes.delete();
        send(PQ_ENQ, 16'h0B0B, a0, w0);
        send(PQ_ENQ, 16'h0909, a1, w1);
        send(PQ_DEQ, 16'h0000, a2, w2);
        chk("b2b_ready_held", w0 + w1 + w2, 0);
        wait_strobes(3);
        chk("b2b_count", strobes.size(), 3);
        if (strobes.size() >= 3) begin
            chk("b2b_first_lat", strobes[0].cyc - a0, 1);
            chk("b2b_gap1", strobes[1].cyc - strobes[0].cyc, 8);
            chk("b2b_gap2", strobes[2].cyc - strobes[0].cyc, 16);
            chk("b2b_s0_kv", strobes[0].kv, 16'h0B0B);
            chk("b2b_s1_kv", strobes[1].kv, 16'h0909);
            chk("b2b_s1_op", {strobes[1].e, strobes[1].d}, 2'b10);
            chk("b2b_s2_op", {strobes[2].e, strobes[2].d}, 2'b01);
        end
        wait_idle("b2b_idle");

        // DEQ on empty PQ: dropped with error pulse
        pq_empty = 1'b1;
        strobes.delete();
        send(PQ_DEQ, 16'h0000, a0, w0);
        tick();
        chk("uf_err", err_underflow, 1);
        chk("uf_no_deq", deq, 0);
        chk("uf_fifo_empty", busy, 0);
        tick();
        chk("uf_err_pulse", err_underflow, 0);
        chk("uf_no_strobe", strobes.size(), 0);

        // REPL with non-empty PQ, then REPL on empty PQ
        pq_empty = 1'b0;
        strobes.delete();
        send(PQ_REPL, 16'h2121, a0, w0);
        tick();
        chk("repl_strobe", {enq, deq}, 2'b11);
        chk("repl_kvi", kvi, 16'h2121);
        pq_empty = 1'b1;
        send(PQ_REPL, 16'h2C2C, a1, w1);
        wait_strobes(2);
        chk("repl_count", strobes.size(), 2);
        if (strobes.size() >= 2) begin
            chk("repl_gap", strobes[1].cyc - strobes[0].cyc, 4);
            chk("repl_empty_op", {strobes[1].e, strobes[1].d}, 2'b10);
            chk("repl_empty_kv", strobes[1].kv, 16'h2C2C);
        end
        wait_idle("repl_idle");

        // ENQ stalled by a full PQ, FIFO filled behind it
        pq_empty = 1'b0;
        pq_full  = 1'b1;
        strobes.delete();
        send(PQ_ENQ, 16'h5555, a0, w0);
        repeat (20) tick();
        chk("full_no_strobe", strobes.size(), 0);
        chk("full_busy", busy, 1);
        send(PQ_ENQ, 16'h0101, a1, w1);
        send(PQ_DEQ, 16'h0000, a2, w2);
        send(PQ_ENQ, 16'h0303, a2, w2);
        chk("fifo_full_ready", req_ready, 0);
        req_valid = 1'b1;
        req_op    = PQ_ENQ;
        req_kv    = 16'h0404;
        repeat (3) tick();
        chk("fifo_full_hold", req_ready, 0);
        pq_full = 1'b0;
        r = cyc;
        tick();
        chk("release_strobe", {enq, deq}, 2'b10);
        chk("release_kvi", kvi, 16'h5555);
        chk("release_ready", req_ready, 1);
        send(PQ_ENQ, 16'h0404, a1, w1);
        wait_strobes(5);
        chk("full_total", strobes.size(), 5);
        if (strobes.size() >= 5) begin
            chk("release_latency_ok", (strobes[0].cyc - r) <= 2, 1);
            chk("full_s2_op", {strobes[2].e, strobes[2].d}, 2'b01);
            chk("full_s4_kv", strobes[4].kv, 16'h0404);
        end
        wait_idle("full_idle");

        // DEQ followed by ENQ queued behind an ENQ in its gap
        pq_empty = 1'b0;
        strobes.delete();
        send(PQ_ENQ, 16'h1111, a0, w0);
        send(PQ_DEQ, 16'h0000, a1, w1);
        send(PQ_ENQ, 16'h0707, a2, w2);
`ifdef PQ_SHAPER_COALESCE_EN
        exp_n = 2;
`else
        exp_n = 3;
`endif
        wait_strobes(exp_n);
        wait_idle("coal_idle");
        chk("coal_count", strobes.size(), exp_n);
`ifdef PQ_SHAPER_COALESCE_EN
        if (strobes.size() >= 2) begin
            chk("coal_op", {strobes[1].e, strobes[1].d}, 2'b11);
            chk("coal_kv", strobes[1].kv, 16'h0707);
            chk("coal_gap", strobes[1].cyc - strobes[0].cyc, 8);
        end
`else
        if (strobes.size() >= 3) begin
            chk("nocoal_s1_op", {strobes[1].e, strobes[1].d}, 2'b01);
            chk("nocoal_s2_op", {strobes[2].e, strobes[2].d}, 2'b10);
            chk("nocoal_s2_kv", strobes[2].kv, 16'h0707);
            chk("nocoal_gap", strobes[2].cyc - strobes[1].cyc, 4);
        end
`endif

        // Reset during a strobe/gap with requests queued
        strobes.delete();
        send(PQ_ENQ, 16'h7777, a0, w0);
        send(PQ_ENQ, 16'h6666, a1, w1);
        chk("pre_rst_enq", enq, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_enq", enq, 0);
        chk("mid_rst_kvi", kvi, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 1);
        tick();
        rst = 1'b0;
        strobes.delete();
        repeat (20) tick();
        chk("post_rst_no_strobe", strobes.size(), 0);
        chk("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pq_req_shaper.md
Name: pq_req_shaper

Overview:
- Front-end stage directly upstream of the pipelined-heap priority queue (pheap_pq).
- Accepts enqueue, dequeue and replace requests from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues each request to the PQ as a single-cycle enq/deq strobe, enforcing the minimum inter-operation spacing the heap pipeline needs.
- Never dequeues an empty PQ and never enqueues a full one.

Parameters:
- FIFO_DEPTH, 4: request buffer entries; power of 2, ≥2.
- ENQ_SPACING, 8: minimum cycles from an enq-only strobe to the next strobe.
- DEQ_SPACING, 4: minimum cycles from a deq-only strobe to the next strobe.
- REPL_SPACING, 4: minimum cycles from an enq+deq (replace) strobe to the next strobe.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  producer request valid.
- req_ready  out  1  shaper can accept a request.
- req_op  in  2  pq_op_t: 00 NOP, 01 ENQ, 10 DEQ, 11 REPL.
- req_kv  in  KEY_WIDTH+VAL_WIDTH  {key,val} for ENQ/REPL.
- enq  out  1  enqueue strobe to PQ.
- deq  out  1  dequeue strobe to PQ.
- kvi  out  KEY_WIDTH+VAL_WIDTH  {key,val} to PQ, valid with enq.
- pq_empty  in  1  PQ empty flag.
- pq_full  in  1  PQ full flag.
- err_underflow  out  1  one-cycle pulse: DEQ dropped because PQ empty.
- busy  out  1  FIFO non-empty or spacing counter running.

Behaviour:
- Reset (async): enq=0, deq=0, kvi=0, err_underflow=0, busy=0, req_ready=1; FIFO emptied; spacing counter=0; FSM in IDLE.
- Reset mid-operation: pending requests are discarded; any strobe drops immediately.
- Handshake:
  - Transfer occurs on a rising edge with req_valid && req_ready.
  - req_ready = !fifo_full, taken from registered count; no same-cycle bypass when full.
  - NOP is accepted and not stored.
- All PQ-side outputs are registered.
- Latency: with FIFO empty and FSM IDLE, a request accepted at edge t produces its strobe in the cycle following edge t+1.
- FSM:
  - IDLE: if FIFO non-empty, evaluate head:
    - ENQ && !pq_full -> assert enq, pop, go to GAP.
    - ENQ && pq_full -> stay in IDLE, head retained (stall).
    - DEQ && !pq_empty -> assert deq, pop, go to GAP.
    - DEQ && pq_empty -> pop, pulse err_underflow, no strobe, remain IDLE.
    - REPL && !pq_empty -> assert enq and deq together, pop, go to GAP.
    - REPL && pq_empty -> issue as ENQ (enq only, ENQ_SPACING).
  - GAP: counter loaded with SPACING-1 of the issued op; decrements each cycle; returns to IDLE when it reaches 0.
- Strobes are high for exactly one cycle.
- Consecutive strobes are separated by at least the spacing of the earlier op: strobe at cycle N means next strobe no earlier than N+SPACING.
- pq_empty and pq_full are sampled only in IDLE, after spacing expiry, so the flags have settled.
- kvi holds its last issued value when no enq strobe is active.
- Simultaneous push and pop: allowed whenever not full; count is unchanged.
- Pointer wrap-around uses log2(FIFO_DEPTH)-bit pointers plus a separate count.
- busy = (count != 0) || (state == GAP).

Optional Feature:
- Macro: PQ_SHAPER_COALESCE_EN.
- Defined:
  - In IDLE, if head is DEQ, the entry behind it is ENQ, and pq_empty=0, both are popped in one cycle and issued as one REPL strobe with the ENQ's kv, using REPL_SPACING.
  - If pq_empty=1, the head DEQ follows the normal drop/err path.
- Not defined: every entry is issued individually; no two-entry lookahead logic is present.

Decomposition:
- pq_pkg additions:
  - typedef enum logic [1:0] pq_op_t {PQ_NOP, PQ_ENQ, PQ_DEQ, PQ_REPL}.
  - typedef kv_t = logic [KEY_WIDTH+VAL_WIDTH-1:0].
  - Default spacing constants: PQ_ENQ_SPACING=8, PQ_DEQ_SPACING=4, PQ_REPL_SPACING=4.
- One sub-module, pq_req_fifo: synchronous FIFO of {pq_op_t, kv_t}, with count output, head and next-to-head peek (the latter used by the coalesce feature), and a pop1/pop2 interface.

Test Plan:
- Reset, then ENQ <15,15> with pq_empty=1, pq_full=0 -> enq pulse with kvi={15,15} one cycle after acceptance edge; busy low after 8 cycles.
- Back-to-back ENQ <11>, ENQ <9>, DEQ presented on consecutive cycles -> strobes at cycles N, N+8, N+16 (deq); req_ready never drops with FIFO_DEPTH=4.
- DEQ with pq_empty=1 -> no deq strobe; err_underflow high for one cycle; FIFO count returns to 0.
- REPL <33,33> with pq_empty=0 -> enq=deq=1 in the same cycle, kvi={33,33}; next strobe ≥4 cycles later. REPL <44> with pq_empty=1 -> enq only.
- ENQ <85> with pq_full=1 held 20 cycles -> no strobe, busy=1; release pq_full -> strobe within 2 cycles. Fill FIFO with 4 more requests -> req_ready=0 until a pop.
- With PQ_SHAPER_COALESCE_EN: DEQ then ENQ <7,7> queued, pq_empty=0 -> single enq+deq strobe, kvi={7,7}, FIFO count drops by 2. Assert rst mid-GAP -> outputs 0 immediately, queued requests discarded.
